demux_1x8_tdm: RTL and testbench

Serial-to-parallel 1-to-8 time-division demultiplexer: the receive-side counterpart of the 8:1 select mux. It accepts one data bit per qualified cycle, steers each bit to one of eight slots using an internal 3-bit slot counter started by a frame sync, and updates eight registered outputs together once a full frame has arrived. It sits after a serialised link driven by the 8:1 mux and rebuilds the original I0..I7 word.

---
 rtl/demux_1x8_tdm_if.sv | 30 +++
 rtl/demux_1x8_tdm.sv | 115 +++++++++++
 tb/tb_demux_1x8_tdm.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/demux_1x8_tdm_if.sv
// Bus bundle for demux_1x8_tdm: serial input qualifiers plus registered parallel word and status.
// frame_err exists only when FRAME_ERR_EN is defined.
interface demux_1x8_tdm_if;
    logic d;
    logic valid;
    logic sync;
    logic y0, y1, y2, y3, y4, y5, y6, y7;
    logic s2, s1, s0;
    logic frame_valid;
    logic busy;
`ifdef FRAME_ERR_EN
    logic frame_err;
`endif

    modport master (
        output d, valid, sync,
        input  y0, y1, y2, y3, y4, y5, y6, y7, s2, s1, s0, frame_valid, busy
`ifdef FRAME_ERR_EN
        , input frame_err
`endif
    );

    modport slave (
        input  d, valid, sync,
        output y0, y1, y2, y3, y4, y5, y6, y7, s2, s1, s0, frame_valid, busy
`ifdef FRAME_ERR_EN
        , output frame_err
`endif
    );
endinterface

// File: rtl/demux_1x8_tdm.sv
// 1-to-8 TDM demultiplexer: collects eight qualified serial bits after a frame sync and
// publishes them together. Optional restart pulse output enabled by FRAME_ERR_EN.
module demux_1x8_tdm #(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic            clk,
    input logic            rst,
    demux_1x8_tdm_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] y_q, y_d;
    logic       frame_valid_q, frame_valid_d;
    logic [7:0] frame_in;
    logic [7:0] frame_out;
`ifdef FRAME_ERR_EN
    logic       frame_err_q, frame_err_d;
`endif

    // Completed word as seen on the final edge: slot 7 comes straight from d.
    always_comb begin
        frame_in = {bus.d, shadow_q[6:0]};
        for (int k = 0; k < 8; k++) begin
            frame_out[k] = MSB_FIRST ? frame_in[7-k] : frame_in[k];
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        y_d           = y_q;
        frame_valid_d = 1'b0;
`ifdef FRAME_ERR_EN
        frame_err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.valid && bus.sync) begin
                    shadow_d    = 8'h00;
                    shadow_d[0] = bus.d;
                    cnt_d       = 3'd1;
                    state_d     = StFill;
                end
            end
            StFill: begin
                if (bus.valid) begin
                    if (bus.sync) begin
                        // Restart: drop the partial frame, this bit becomes slot 0.
                        shadow_d    = 8'h00;
                        shadow_d[0] = bus.d;
                        cnt_d       = 3'd1;
`ifdef FRAME_ERR_EN
                        frame_err_d = 1'b1;
`endif
                    end else if (cnt_q == 3'd7) begin
                        shadow_d      = frame_in;
                        y_d           = frame_out;
                        frame_valid_d = 1'b1;
                        cnt_d         = 3'd0;
                        state_d       = StIdle;
                    end else begin
                        shadow_d[cnt_q] = bus.d;
                        cnt_d           = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 3'd0;
            shadow_q      <= 8'h00;
            y_q           <= 8'h00;
            frame_valid_q <= 1'b0;
`ifdef FRAME_ERR_EN
            frame_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
`ifdef FRAME_ERR_EN
            frame_err_q   <= frame_err_d;
`endif
        end
    end

    assign bus.y0          = y_q[0];
    assign bus.y1          = y_q[1];
    assign bus.y2          = y_q[2];
    assign bus.y3          = y_q[3];
    assign bus.y4          = y_q[4];
    assign bus.y5          = y_q[5];
    assign bus.y6          = y_q[6];
    assign bus.y7          = y_q[7];
    assign bus.s2          = cnt_q[2];
    assign bus.s1          = cnt_q[1];
    assign bus.s0          = cnt_q[0];
    assign bus.frame_valid = frame_valid_q;
    assign bus.busy        = (state_q == StFill);
`ifdef FRAME_ERR_EN
    assign bus.frame_err   = frame_err_q;
`endif

endmodule

// File: tb/tb_demux_1x8_tdm.sv
// Directed bench for demux_1x8_tdm: one instance per bit order, driven with identical streams.
module tb_demux_1x8_tdm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errs = 0;

    always #5 clk = ~clk;

    demux_1x8_tdm_if bus_lsb ();
    demux_1x8_tdm_if bus_msb ();

    assign bus_msb.d     = bus_lsb.d;
    assign bus_msb.valid = bus_lsb.valid;
    assign bus_msb.sync  = bus_lsb.sync;

    demux_1x8_tdm #(.MSB_FIRST(1'b0)) u_dut_lsb (.clk(clk), .rst(rst), .bus(bus_lsb));
    demux_1x8_tdm #(.MSB_FIRST(1'b1)) u_dut_msb (.clk(clk), .rst(rst), .bus(bus_msb));

    wire [7:0] y_lsb = {bus_lsb.y7, bus_lsb.y6, bus_lsb.y5, bus_lsb.y4,
                        bus_lsb.y3, bus_lsb.y2, bus_lsb.y1, bus_lsb.y0};
    wire [7:0] y_msb = {bus_msb.y7, bus_msb.y6, bus_msb.y5, bus_msb.y4,
                        bus_msb.y3, bus_msb.y2, bus_msb.y1, bus_msb.y0};
    wire [2:0] s_lsb = {bus_lsb.s2, bus_lsb.s1, bus_lsb.s0};
    wire [2:0] s_msb = {bus_msb.s2, bus_msb.s1, bus_msb.s0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic dd);
        bus_lsb.valid = v;
        bus_lsb.sync  = s;
        bus_lsb.d     = dd;
        @(posedge clk);
        #1;
    endtask

    // Sends word w, bit 0 first, with sync on the first bit; frame_valid expected only at the end.
    task automatic send_word(input string tag, input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, k == 0, w[k]);
            check({tag, "_fv"}, bus_lsb.frame_valid, k == 7);
            check({tag, "_s"}, s_lsb, (k == 7) ? 3'd0 : 3'(k + 1));
        end
    endtask

    initial begin
        bus_lsb.valid = 1'b0;
        bus_lsb.sync  = 1'b0;
        bus_lsb.d     = 1'b0;

        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom));
        end
        check("rst_y", y_lsb, 8'h00);
        check("rst_y_msb", y_msb, 8'h00);
        check("rst_s", s_lsb, 3'd0);
        check("rst_busy", bus_lsb.busy, 1'b0);
        check("rst_fv", bus_lsb.frame_valid, 1'b0);
`ifdef FRAME_ERR_EN
        check("rst_ferr", bus_lsb.frame_err, 1'b0);
`endif
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b1);  // valid without sync in idle: ignored
        check("idle_ign_s", s_lsb, 3'd0);
        check("idle_ign_busy", bus_lsb.busy, 1'b0);

        // Basic frame 1,0,1,1,0,0,1,0 -> Y0..Y7; word {y7..y0} = 8'h4D
        send_word("basic", 8'h4D);
        check("basic_y", y_lsb, 8'h4D);
        check("basic_y_msb", y_msb, 8'hB2);
        check("basic_busy", bus_lsb.busy, 1'b0);
        check("basic_s_msb", s_msb, 3'd0);
        step(1'b0, 1'b0, 1'b0);
        check("basic_fv_drop", bus_lsb.frame_valid, 1'b0);
        check("basic_hold", y_lsb, 8'h4D);

        // Gapped frame: zero y first, then same data with a 3-cycle gap after bit 4
        send_word("zero", 8'h00);
        check("zero_y", y_lsb, 8'h00);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom));
            check("gap_s", s_lsb, 3'd4);
            check("gap_busy", bus_lsb.busy, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("gap_partial_y", y_lsb, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        check("gap_fv", bus_lsb.frame_valid, 1'b1);
        check("gap_y", y_lsb, 8'h4D);
        check("gap_y_msb", y_msb, 8'hB2);

        // Restart after 5 bits
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        check("rs_s5", s_lsb, 3'd5);
        step(1'b1, 1'b1, 1'b1);
        check("rs_s", s_lsb, 3'd1);
        check("rs_busy", bus_lsb.busy, 1'b1);
        check("rs_fv", bus_lsb.frame_valid, 1'b0);
        check("rs_y_hold", y_lsb, 8'h4D);
`ifdef FRAME_ERR_EN
        check("rs_ferr", bus_lsb.frame_err, 1'b1);
`endif
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b0);
`ifdef FRAME_ERR_EN
            check("rs_ferr_once", bus_lsb.frame_err, 1'b0);
`endif
        end
        check("rs_fv_end", bus_lsb.frame_valid, 1'b1);
        check("rs_y", y_lsb, 8'h01);
        check("rs_y_msb", y_msb, 8'h80);

        // Back-to-back frames, no bubble
        send_word("b2b_a5", 8'hA5);
        check("b2b_a5_y", y_lsb, 8'hA5);
        send_word("b2b_3c", 8'h3C);
        check("b2b_3c_y", y_lsb, 8'h3C);
        check("b2b_3c_y_msb", y_msb, 8'h3C);

        // Third frame aborted by reset after bit 3
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("mr_s3", s_lsb, 3'd3);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        check("mr_y", y_lsb, 8'h00);
        check("mr_s", s_lsb, 3'd0);
        check("mr_busy", bus_lsb.busy, 1'b0);
        check("mr_fv", bus_lsb.frame_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1);
            check("mr_after_fv", bus_lsb.frame_valid, 1'b0);
            check("mr_after_s", s_lsb, 3'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
